psum_drain: RTL

Accumulates the 32-layer partial-sum bus produced by the convolution array over a fixed number of passes (one pass per kernel row). It then quantizes each layer's 4 results (ReLU, shift, saturate to 8 bits) and streams them out one layer per beat over a valid/ready handshake. It sits directly downstream of `conv`, on the psum side, and feeds the output feature-map buffer.

---
 rtl/cnn_pkg.sv | 23 ++
 rtl/psum_quant.sv | 26 ++
 rtl/psum_drain.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN datapath constants, psum bus slicing helper and drain FSM states.
package cnn_pkg;

    localparam int unsigned LAYERS = 32;
    localparam int unsigned PIX    = 4;
    localparam int unsigned PW     = 32;

    typedef enum logic {
        ACC   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    // Bit offset of pixel `pix` of layer `layer` on a flat psum bus.
    function automatic int unsigned psum_lsb(
        input int unsigned layer,
        input int unsigned pix,
        input int unsigned pix_per_layer,
        input int unsigned pw
    );
        return (layer * pix_per_layer + pix) * pw;
    endfunction

endpackage

// File: rtl/psum_quant.sv
// Quantizes one signed accumulator: ReLU, arithmetic right shift, saturate to 8 bits.
module psum_quant #(
    parameter int unsigned AW    = 35,
    parameter int unsigned SHIFT = 8
) (
    input  logic signed [AW-1:0] acc,
    output logic [7:0]           q
);

    logic [AW-1:0] shifted;

    // Negative values clamp to zero; positive ones are truncated then saturated.
    always_comb begin
        shifted = '0;
        q       = '0;
        shifted = $unsigned(acc) >> SHIFT;
        if (acc[AW-1]) begin
            q = '0;
        end else if (|shifted[AW-1:8]) begin
            q = '1;
        end else begin
            q = shifted[7:0];
        end
    end

endmodule

// File: rtl/psum_drain.sv
// Accumulates PASSES psum beats per layer/pixel, then drains one quantized layer per beat.
module psum_drain
    import cnn_pkg::state_t, cnn_pkg::ACC, cnn_pkg::DRAIN, cnn_pkg::psum_lsb;
#(
    parameter int unsigned LAYERS = cnn_pkg::LAYERS,
    parameter int unsigned PIX    = cnn_pkg::PIX,
    parameter int unsigned PW     = cnn_pkg::PW,
    parameter int unsigned PASSES = 7,
    parameter int unsigned SHIFT  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       psum_valid,
    input  logic [LAYERS*PIX*PW-1:0]   psum,
    output logic                       acc_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PIX*8-1:0]           out_data,
    output logic [4:0]                 out_layer,
    output logic                       out_last,
    output logic                       drop_err
);

    localparam int unsigned PCW = $clog2(PASSES + 1);
    localparam int unsigned AW  = PW + PCW;
    localparam int unsigned LCW = $clog2(LAYERS);

    state_t                 state;
    state_t                 state_nxt;
    logic signed [AW-1:0]   acc [LAYERS][PIX];
    logic signed [AW-1:0]   sel [PIX];
    logic [PCW-1:0]         pass_cnt;
    logic [LCW-1:0]         layer_cnt;
    logic                   accept;
    logic                   drop;
    logic                   out_fire;
    logic                   last_pass;
    logic                   last_layer;

    assign accept     = psum_valid && (state == ACC);
    assign drop       = psum_valid && (state != ACC);
    assign out_fire   = (state == DRAIN) && out_ready;
    assign last_pass  = (pass_cnt == PCW'(PASSES - 1));
    assign last_layer = (layer_cnt == LCW'(LAYERS - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACC;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        acc_ready = 1'b0;
        out_valid = 1'b0;
        case (state)
            ACC: begin
                acc_ready = 1'b1;
                if (accept && last_pass) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                out_valid = 1'b1;
                if (out_ready && last_layer) begin
                    state_nxt = ACC;
                end
            end
            default: state_nxt = ACC;
        endcase
    end

    // Accumulator array: first pass loads, later passes add (sign-extended).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned n = 0; n < LAYERS; n++) begin
                for (int unsigned p = 0; p < PIX; p++) begin
                    acc[n][p] <= '0;
                end
            end
        end else if (accept) begin
            for (int unsigned n = 0; n < LAYERS; n++) begin
                for (int unsigned p = 0; p < PIX; p++) begin
                    if (pass_cnt == '0) begin
                        acc[n][p] <= AW'($signed(psum[psum_lsb(n, p, PIX, PW) +: PW]));
                    end else begin
                        acc[n][p] <= acc[n][p] + AW'($signed(psum[psum_lsb(n, p, PIX, PW) +: PW]));
                    end
                end
            end
        end
    end

    // Pass counter: wraps to zero on the beat that completes the frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt <= '0;
        end else if (accept) begin
            pass_cnt <= last_pass ? '0 : pass_cnt + 1'b1;
        end
    end

    // Layer counter: advances on each output handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            layer_cnt <= '0;
        end else if (out_fire) begin
            layer_cnt <= last_layer ? '0 : layer_cnt + 1'b1;
        end
    end

    // Sticky flag for psum beats arriving while not ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_err <= 1'b0;
        end else if (drop) begin
            drop_err <= 1'b1;
        end
    end

    // Layer select mux feeding the quantizers.
    always_comb begin
        for (int unsigned p = 0; p < PIX; p++) begin
            sel[p] = acc[layer_cnt][p];
        end
    end

    for (genvar g = 0; g < PIX; g++) begin : g_quant
        psum_quant #(
            .AW    (AW),
            .SHIFT (SHIFT)
        ) u_quant (
            .acc (sel[g]),
            .q   (out_data[g*8 +: 8])
        );
    end

    assign out_layer = 5'(layer_cnt);
    assign out_last  = out_valid && last_layer;

endmodule
